// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius/Simon game controller.
package genius_pkg;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_ADD      = 3'd1,
        PH_SHOW_ON  = 3'd2,
        PH_SHOW_GAP = 3'd3,
        PH_WAIT_IN  = 3'd4,
        PH_WIN      = 3'd5,
        PH_LOSE     = 3'd6
    } phase_t;

    // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int sym_w(input int n_colors);
        return (n_colors > 1) ? $clog2(n_colors) : 1;
    endfunction

    function automatic int lvl_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/genius_game_ctrl_if.sv
// Button/display bundle between the game core and its player-side logic.
interface genius_game_ctrl_if #(
    parameter int N_COLORS = 3,
    parameter int MAX_LEN  = 16
);
    localparam int SYM_W = genius_pkg::sym_w(N_COLORS);
    localparam int LVL_W = genius_pkg::lvl_w(MAX_LEN);

    logic                start;
    logic [N_COLORS-1:0] bt;
    logic                show_en;
    logic [SYM_W-1:0]    show_sym;
    logic [LVL_W-1:0]    level;
    logic [LVL_W-1:0]    in_idx;
    logic [2:0]          phase;
    logic                win;
    logic                lose;

    modport master (
        output start, bt,
        input  show_en, show_sym, level, in_idx, phase, win, lose
    );

    modport slave (
        input  start, bt,
        output show_en, show_sym, level, in_idx, phase, win, lose
    );
endinterface

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Galois LFSR with a combinational mod-N symbol draw.
module genius_lfsr
    import genius_pkg::*;
#(
    parameter int          N_COLORS  = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         SYM_W     = sym_w(N_COLORS)
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic [SYM_W-1:0] draw
);

    logic [15:0] lfsr;
    logic [7:0]  rem;

    always_ff @(posedge clock) begin
        if (!reset_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    // Repeated subtraction bounded by 255/N keeps the modulo a single cycle
    always_comb begin
        rem = lfsr[7:0];
        for (int i = 0; i < 256 / N_COLORS; i++) begin
            if (rem >= 8'(N_COLORS))
                rem = rem - 8'(N_COLORS);
        end
        draw = rem[SYM_W-1:0];
    end

endmodule

// File: rtl/genius_game_ctrl.sv
// Genius/Simon core: grows a random sequence, plays it back, checks presses.
//
// state       | meaning
// IDLE        | waiting for start after reset
// ADD         | append one random symbol, grow level
// SHOW_ON     | symbol seq[ptr] lit for SHOW_CYC cycles
// SHOW_GAP    | dark for GAP_CYC cycles, then next symbol or input
// WAIT_IN     | checking player presses against the sequence
// WIN         | full MAX_LEN sequence repeated correctly
// LOSE        | wrong press, multi-press or timeout
module genius_game_ctrl
    import genius_pkg::*;
#(
    parameter int          N_COLORS    = 3,
    parameter int          MAX_LEN     = 16,
    parameter int          SHOW_CYC    = 25_000_000,
    parameter int          GAP_CYC     = 5_000_000,
    parameter int          TIMEOUT_CYC = 250_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset_n,
    genius_game_ctrl_if.slave  gif
);

    localparam int SYM_W     = sym_w(N_COLORS);
    localparam int LVL_W     = lvl_w(MAX_LEN);
    localparam int IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int SEQ_DEPTH = 1 << IDX_W;
    localparam int CNT_MAX0  = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int CNT_MAX   = (CNT_MAX0 > TIMEOUT_CYC) ? CNT_MAX0 : TIMEOUT_CYC;
    localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LD = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);
    localparam logic [LVL_W-1:0] MAX_L   = LVL_W'(MAX_LEN);

    phase_t           state, state_nxt;
    logic [LVL_W-1:0] level, level_nxt;
    logic [LVL_W-1:0] ptr, ptr_nxt;
    logic [LVL_W-1:0] in_idx, in_idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             seq_we;
    logic [SYM_W-1:0] draw;
    logic [SYM_W-1:0] bt_sym;
    logic             press_ok;
    logic [SYM_W-1:0] seq [SEQ_DEPTH];

    genius_lfsr #(
        .N_COLORS  (N_COLORS),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .draw    (draw)
    );

    always_comb begin
        bt_sym = '0;
        for (int i = 0; i < N_COLORS; i++) begin
            if (gif.bt[i])
                bt_sym = SYM_W'(i);
        end
        press_ok = $onehot(gif.bt) && (bt_sym == seq[in_idx[IDX_W-1:0]]);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= PH_IDLE;
            level  <= '0;
            ptr    <= '0;
            in_idx <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            level  <= level_nxt;
            ptr    <= ptr_nxt;
            in_idx <= in_idx_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (seq_we)
            seq[level[IDX_W-1:0]] <= draw;
    end

    // One down-counter serves show, gap and press timeout; zero is terminal count
    always_comb begin
        state_nxt  = state;
        level_nxt  = level;
        ptr_nxt    = ptr;
        in_idx_nxt = in_idx;
        cnt_nxt    = cnt;
        seq_we     = 1'b0;
        case (state)
            PH_IDLE, PH_WIN, PH_LOSE: begin
                if (gif.start) begin
                    state_nxt = PH_ADD;
                    level_nxt = '0;
                end
            end
            PH_ADD: begin
                seq_we    = 1'b1;
                level_nxt = level + ONE_L;
                ptr_nxt   = '0;
                cnt_nxt   = SHOW_LD;
                state_nxt = PH_SHOW_ON;
            end
            PH_SHOW_ON: begin
                if (cnt == '0) begin
                    cnt_nxt   = GAP_LD;
                    state_nxt = PH_SHOW_GAP;
                end else begin
                    cnt_nxt = cnt - ONE_C;
                end
            end
            PH_SHOW_GAP: begin
                if (cnt == '0) begin
                    if (ptr + ONE_L == level) begin
                        in_idx_nxt = '0;
                        cnt_nxt    = TMO_LD;
                        state_nxt  = PH_WAIT_IN;
                    end else begin
                        ptr_nxt   = ptr + ONE_L;
                        cnt_nxt   = SHOW_LD;
                        state_nxt = PH_SHOW_ON;
                    end
                end else begin
                    cnt_nxt = cnt - ONE_C;
                end
            end
            PH_WAIT_IN: begin
                if (gif.bt == '0) begin
                    if (cnt == '0)
                        state_nxt = PH_LOSE;
                    else
                        cnt_nxt = cnt - ONE_C;
                end else if (press_ok) begin
                    in_idx_nxt = in_idx + ONE_L;
                    cnt_nxt    = TMO_LD;
                    if (in_idx + ONE_L == level)
                        state_nxt = (level == MAX_L) ? PH_WIN : PH_ADD;
                end else begin
                    state_nxt = PH_LOSE;
                end
            end
            default: state_nxt = PH_IDLE;
        endcase
    end

    assign gif.show_en  = (state == PH_SHOW_ON);
    assign gif.show_sym = (state == PH_SHOW_ON) ? seq[ptr[IDX_W-1:0]] : '0;
    assign gif.level    = level;
    assign gif.in_idx   = in_idx;
    assign gif.phase    = state;
    assign gif.win      = (state == PH_WIN);
    assign gif.lose     = (state == PH_LOSE);

endmodule
